// File: rtl/vc_test_multi_port_mem_pkg.sv
// Shared message layout, type encodings and sizing helpers for the
// multi-port behavioural test memory.
package vc_test_multi_port_mem_pkg;

  typedef enum logic {
    VC_MEM_REQ_MSG_TYPE_READ  = 1'b0,
    VC_MEM_REQ_MSG_TYPE_WRITE = 1'b1
  } vc_mem_type_e;

  localparam int VC_MEM_MSG_TYPE_SZ = 1;

  // req msg  = {type, addr, len, data}; resp msg = {type, len, data}
  function automatic int vc_mem_len_sz(input int data_sz);
    return (data_sz > 8) ? $clog2(data_sz / 8) : 1;
  endfunction

  function automatic int vc_mem_req_msg_sz(input int addr_sz, input int data_sz);
    return VC_MEM_MSG_TYPE_SZ + addr_sz + vc_mem_len_sz(data_sz) + data_sz;
  endfunction

  function automatic int vc_mem_resp_msg_sz(input int data_sz);
    return VC_MEM_MSG_TYPE_SZ + vc_mem_len_sz(data_sz) + data_sz;
  endfunction

  function automatic int vc_mem_nbytes(input int len, input int data_sz);
    return (len == 0) ? data_sz / 8 : len;
  endfunction

  function automatic int vc_cnt_sz(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/vc_test_multi_port_mem_port_pipe.sv
// Per-port response path: fixed-latency delay line feeding an in-order
// response FIFO, with occupancy-based request ready.
module vc_test_mem_port_pipe
  import vc_test_multi_port_mem_pkg::*;
#(
  parameter int p_latency     = 1,
  parameter int p_queue_depth = 4,
  parameter int p_msg_sz      = 35
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_val,
  output logic                req_rdy,
  input  logic [p_msg_sz-1:0] resp_in,
  output logic                resp_val,
  input  logic                resp_rdy,
  output logic [p_msg_sz-1:0] resp_msg
);

  localparam int c_cnt_w = vc_cnt_sz(p_queue_depth);
  localparam int c_ptr_w = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;

  logic [c_cnt_w-1:0]  occ;
  logic [c_cnt_w-1:0]  fifo_cnt;
  logic [c_ptr_w-1:0]  wr_ptr;
  logic [c_ptr_w-1:0]  rd_ptr;
  logic [p_msg_sz-1:0] fifo_mem [p_queue_depth];
  logic [p_latency-1:0] vld_p;
  logic [p_msg_sz-1:0] msg_p [p_latency];
  logic                accept;
  logic                fire;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] ptr);
    return (int'(ptr) == p_queue_depth - 1) ? '0 : ptr + 1'b1;
  endfunction

  // Occupancy counts every accepted request until its response fires, so
  // the FIFO below can never overflow and the delay line never stalls.
  assign req_rdy    = !reset && (occ < c_cnt_w'(p_queue_depth));
  assign accept     = req_val && req_rdy;
  assign fifo_empty = (fifo_cnt == '0);
  assign resp_val   = !fifo_empty || vld_p[p_latency-1];
  assign resp_msg   = fifo_empty ? msg_p[p_latency-1] : fifo_mem[rd_ptr];
  assign fire       = resp_val && resp_rdy;
  assign push       = vld_p[p_latency-1] && !(fifo_empty && resp_rdy);
  assign pop        = !fifo_empty && resp_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else begin
      occ <= occ + c_cnt_w'(accept) - c_cnt_w'(fire);
    end
  end

  // Delay line: stage 0 captures at the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int s = 1; s < p_latency; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    msg_p[0] <= resp_in;
    for (int s = 1; s < p_latency; s++) msg_p[s] <= msg_p[s-1];
  end

  // Response FIFO, bypassed when empty so the last stage is seen directly
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + c_cnt_w'(push) - c_cnt_w'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= msg_p[p_latency-1];
  end

endmodule

// File: rtl/vc_test_multi_port_mem.sv
// N-port byte-addressed behavioural test memory with fixed response
// latency and per-port response queueing.
module vc_test_multi_port_mem
  import vc_test_multi_port_mem_pkg::*;
#(
  parameter  int p_num_ports   = 2,
  parameter  int p_mem_sz      = 1024,
  parameter  int p_addr_sz     = 32,
  parameter  int p_data_sz     = 32,
  parameter  int p_latency     = 1,
  parameter  int p_queue_depth = 4,
  localparam int c_req_msg_sz  = vc_mem_req_msg_sz(p_addr_sz, p_data_sz),
  localparam int c_resp_msg_sz = vc_mem_resp_msg_sz(p_data_sz)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [p_num_ports-1:0]               memreq_val,
  output logic [p_num_ports-1:0]               memreq_rdy,
  input  logic [p_num_ports*c_req_msg_sz-1:0]  memreq_msg,
  output logic [p_num_ports-1:0]               memresp_val,
  input  logic [p_num_ports-1:0]               memresp_rdy,
  output logic [p_num_ports*c_resp_msg_sz-1:0] memresp_msg
);

  localparam int c_len_sz = vc_mem_len_sz(p_data_sz);
  localparam int c_bytes  = p_data_sz / 8;
  localparam int c_mem_aw = $clog2(p_mem_sz);

  logic [7:0]            mem [p_mem_sz];
  logic [p_num_ports-1:0] accept;
  logic [p_num_ports-1:0] req_type;
  logic [c_mem_aw-1:0]   req_addr [p_num_ports];
  logic [c_len_sz-1:0]   req_len  [p_num_ports];
  logic [p_data_sz-1:0]  req_data [p_num_ports];

  for (genvar i = 0; i < p_num_ports; i++) begin : g_port
    logic [c_req_msg_sz-1:0]  req;
    logic [p_addr_sz-1:0]     addr_full;
    logic                     unused_addr;
    logic [p_data_sz-1:0]     rd_data;
    logic [c_resp_msg_sz-1:0] resp;

    assign req         = memreq_msg[i*c_req_msg_sz +: c_req_msg_sz];
    assign req_type[i] = req[c_req_msg_sz-1];
    assign addr_full   = req[p_data_sz + c_len_sz +: p_addr_sz];
    assign req_len[i]  = req[p_data_sz +: c_len_sz];
    assign req_data[i] = req[p_data_sz-1:0];
    // Only the low address bits select a byte: addresses wrap modulo p_mem_sz
    assign req_addr[i] = addr_full[c_mem_aw-1:0];
    assign unused_addr = ^addr_full;

    // Little-endian gather; byte index wraps naturally in c_mem_aw bits
    always_comb begin
      rd_data = '0;
      for (int b = 0; b < c_bytes; b++) begin
        if (b < vc_mem_nbytes(int'(req_len[i]), p_data_sz)) begin
          rd_data[b*8 +: 8] = mem[req_addr[i] + c_mem_aw'(b)];
        end
      end
    end

    assign resp = {req_type[i], req_len[i],
                   (req_type[i] == VC_MEM_REQ_MSG_TYPE_WRITE) ? '0 : rd_data};
    assign accept[i] = memreq_val[i] && memreq_rdy[i];

    vc_test_mem_port_pipe #(
      .p_latency     (p_latency),
      .p_queue_depth (p_queue_depth),
      .p_msg_sz      (c_resp_msg_sz)
    ) u_pipe (
      .clk      (clk),
      .reset    (reset),
      .req_val  (memreq_val[i]),
      .req_rdy  (memreq_rdy[i]),
      .resp_in  (resp),
      .resp_val (memresp_val[i]),
      .resp_rdy (memresp_rdy[i]),
      .resp_msg (memresp_msg[i*c_resp_msg_sz +: c_resp_msg_sz])
    );
  end

  // Reads above sample pre-edge contents; later ports override earlier
  // ports on the same byte because their NBAs land last.
  always_ff @(posedge clk) begin
    for (int i = 0; i < p_num_ports; i++) begin
      if (accept[i] && req_type[i] == VC_MEM_REQ_MSG_TYPE_WRITE) begin
        for (int b = 0; b < c_bytes; b++) begin
          if (b < vc_mem_nbytes(int'(req_len[i]), p_data_sz)) begin
            mem[req_addr[i] + c_mem_aw'(b)] <= req_data[i][b*8 +: 8];
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(memreq_val))
        else $error("vc_test_multi_port_mem: unknown value on memreq_val");
      assert (!$isunknown(memresp_rdy))
        else $error("vc_test_multi_port_mem: unknown value on memresp_rdy");
    end
  end

endmodule

// File: tb/tb_vc_test_multi_port_mem.sv
// Directed and random bench for vc_test_multi_port_mem with a per-port
// scoreboard that predicts data, ready, and the exact response-valid cycle.
module tb_vc_test_multi_port_mem;

  localparam int NP    = 3;
  localparam int MEM   = 1024;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int LW    = 2;
  localparam int REQW  = 1 + AW + LW + DW;
  localparam int RESPW = 1 + LW + DW;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  logic                clk = 1'b0;
  logic                reset;
  logic [NP-1:0]       memreq_val;
  logic [NP-1:0]       memreq_rdy;
  logic [NP*REQW-1:0]  memreq_msg;
  logic [NP-1:0]       memresp_val;
  logic [NP-1:0]       memresp_rdy;
  logic [NP*RESPW-1:0] memresp_msg;
  logic [REQW-1:0]     req [NP];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NP; g++) begin : g_req
    assign memreq_msg[g*REQW +: REQW] = req[g];
  end

  vc_test_multi_port_mem #(
    .p_num_ports   (NP),
    .p_mem_sz      (MEM),
    .p_addr_sz     (AW),
    .p_data_sz     (DW),
    .p_latency     (LAT),
    .p_queue_depth (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg)
  );

  typedef struct {
    logic [RESPW-1:0] msg;
    int               due;
  } exp_t;

  exp_t       sb_q [NP][$];
  logic [7:0] mem_m [MEM];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] l);
    logic [31:0] d = '0;
    int n = (l == 2'd0) ? 4 : int'(l);
    for (int b = 0; b < n; b++) d[b*8 +: 8] = mem_m[(int'(a[9:0]) + b) % MEM];
    return d;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    int n = (l == 2'd0) ? 4 : int'(l);
    for (int b = 0; b < n; b++) mem_m[(int'(a[9:0]) + b) % MEM] = d[b*8 +: 8];
  endtask

  task automatic drive(input int p, input logic t, input logic [31:0] a,
                       input logic [1:0] l, input logic [31:0] d);
    memreq_val[p] = 1'b1;
    req[p]        = {t, a, l, d};
  endtask

  task automatic step();
    logic [NP-1:0] acc;
    logic          exp_rdy;
    logic          exp_val;
    logic          t;
    logic [31:0]   a;
    logic [1:0]    l;
    exp_t          e;
    #1;
    acc = '0;
    for (int i = 0; i < NP; i++) begin
      exp_rdy = !reset && (sb_q[i].size() < DEPTH);
      exp_val = (sb_q[i].size() > 0) && (sb_q[i][0].due <= cyc);
      check($sformatf("rdy p%0d c%0d", i, cyc), 64'(memreq_rdy[i]), 64'(exp_rdy));
      check($sformatf("val p%0d c%0d", i, cyc), 64'(memresp_val[i]), 64'(exp_val));
      if (exp_val && memresp_rdy[i]) begin
        e = sb_q[i].pop_front();
        check($sformatf("msg p%0d c%0d", i, cyc), 64'(memresp_msg[i*RESPW +: RESPW]), 64'(e.msg));
      end
      acc[i] = memreq_val[i] && exp_rdy;
    end
    // All reads see pre-cycle memory, then writes apply in port order
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) begin
        t     = req[i][REQW-1];
        a     = req[i][DW+LW +: AW];
        l     = req[i][DW +: LW];
        e.msg = {t, l, (t == WR) ? 32'h0 : model_read(a, l)};
        e.due = cyc + LAT;
        sb_q[i].push_back(e);
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (acc[i] && req[i][REQW-1] == WR)
        model_write(req[i][DW+LW +: AW], req[i][DW +: LW], req[i][DW-1:0]);
    end
    if (reset) for (int i = 0; i < NP; i++) sb_q[i].delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NP; i++) n += sb_q[i].size();
    return n;
  endfunction

  task automatic drain(input int bound);
    int n = 0;
    memreq_val = '0;
    while (n < bound && pending() > 0) begin
      step();
      n++;
    end
    for (int i = 0; i < NP; i++)
      check($sformatf("drain p%0d", i), 64'(sb_q[i].size()), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    memreq_val  = '0;
    memresp_rdy = '1;
    for (int i = 0; i < NP; i++) req[i] = '0;
    for (int i = 0; i < MEM; i++) mem_m[i] = 8'h00;
    @(posedge clk);
    @(negedge clk);

    // Reset state: rdy low, no responses
    step();
    step();
    reset = 1'b0;
    step();

    // Clear the whole array so every later read is defined
    for (int w = 0; w < MEM / 4; w += NP) begin
      memreq_val = '0;
      for (int p = 0; p < NP; p++)
        if (w + p < MEM / 4) drive(p, WR, 32'((w + p) * 4), 2'd0, 32'h0);
      step();
    end
    drain(20);

    // Write then read back on port 0
    drive(0, WR, 32'h100, 2'd0, 32'hdeadbeef);
    step();
    memreq_val = '0;
    drive(0, RD, 32'h100, 2'd0, 32'h0);
    step();
    drain(20);

    // Wrap across the top of memory and address truncation
    drive(0, WR, 32'hFFFF_FFFE, 2'd0, 32'h11223344);
    step();
    drive(0, RD, 32'h0000_03FE, 2'd2, 32'h0);
    step();
    drive(0, RD, 32'h0000_0000, 2'd2, 32'h0);
    step();
    drive(0, RD, 32'h0000_03FF, 2'd3, 32'h0);
    step();
    drain(20);

    // Same-cycle write collision with a concurrent read
    drive(0, WR, 32'h200, 2'd0, 32'hAAAAAAAA);
    drive(1, WR, 32'h200, 2'd0, 32'h55555555);
    drive(2, RD, 32'h200, 2'd0, 32'h0);
    step();
    memreq_val = '0;
    drive(2, RD, 32'h200, 2'd0, 32'h0);
    step();
    drain(20);

    // Backpressure on port 0 while port 1 keeps flowing
    memresp_rdy[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(0, RD, 32'(32'h100 + k), 2'd0, 32'h0);
      drive(1, RD, 32'h200, 2'd1, 32'h0);
      step();
    end
    memreq_val = '0;
    for (int k = 0; k < 3; k++) step();
    memresp_rdy[0] = 1'b1;
    drain(20);

    // Reset with queued responses; memory contents survive
    memresp_rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(0, RD, 32'h100, 2'd0, 32'h0);
      step();
    end
    memreq_val = '0;
    for (int k = 0; k < 4; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    memresp_rdy = '1;
    step();
    drive(0, RD, 32'h100, 2'd0, 32'h0);
    step();
    drain(20);

    // Random traffic on all ports
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < NP; p++) begin
        memreq_val[p]  = ($urandom_range(0, 3) != 0);
        memresp_rdy[p] = ($urandom_range(0, 3) != 0);
        req[p] = {1'($urandom_range(0, 1)), 32'($urandom), 2'($urandom_range(0, 3)), 32'($urandom)};
      end
      step();
    end
    memresp_rdy = '1;
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
